// File: rtl/spn_pkg.sv
// Shared definitions for the SPN cipher core: block widths, sequencer states and the
// PRESENT-style bit permutation used between substitution rounds.
package spn_pkg;

    localparam int unsigned SIZE_64  = 64;
    localparam int unsigned SIZE_128 = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit i moves to (i*size/4) mod (size-1); the top bit stays put. Operates on a
    // 128-bit carrier so one function serves both block widths; bits >= size are zero.
    function automatic logic [127:0] perm(input logic [127:0] x, input int unsigned size);
        logic [127:0] y;
        logic [6:0]   src;
        logic [6:0]   dst;
        y = '0;
        for (int unsigned i = 0; i < 128; i++) begin
            src = 7'(i);
            if (i < size - 1) begin
                dst    = 7'((i * size / 4) % (size - 1));
                y[dst] = x[src];
            end else if (i == size - 1) begin
                y[src] = x[src];
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/spn_round_ctrl.sv
// Round sequencer for the SPN block cipher: owns the cipher state, fetches round keys
// over a req/ack handshake and drives the external substitution layer.
module spn_round_ctrl
    import spn_pkg::*;
#(
    parameter int unsigned SIZE   = 64,
    parameter int unsigned ROUNDS = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_block,
    output logic            rk_req,
    output logic [5:0]      rk_idx,
    input  logic            rk_ack,
    input  logic [SIZE-1:0] rk_data,
    output logic [SIZE-1:0] sub_in,
    input  logic [SIZE-1:0] sub_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_block,
    output logic            busy
);

    if (!(SIZE == SIZE_64 || SIZE == SIZE_128) || ROUNDS > 63) begin : g_param_check
        $error("spn_round_ctrl: SIZE must be 64 or 128 and ROUNDS at most 63");
    end

    state_t          fsm_q, fsm_d;
    logic [SIZE-1:0] state_q, state_d;
    logic [5:0]      round_q, round_d;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_block;
                    round_d = '0;
                    fsm_d   = KEY;
                end
            end
            KEY: begin
                if (rk_ack) begin
                    state_d = state_q ^ rk_data;
                    fsm_d   = (round_q == 6'(ROUNDS)) ? DONE : SUB;
                end
            end
            SUB: begin
                // sub_out is the S-box image of state_q, returned in the same cycle.
                state_d = SIZE'(perm(128'(sub_out), SIZE));
                round_d = round_q + 6'd1;
                fsm_d   = KEY;
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign rk_req    = (fsm_q == KEY);
    assign rk_idx    = round_q;
    assign sub_in    = state_q;
    assign out_valid = (fsm_q == DONE);
    assign out_block = state_q;
    assign busy      = (fsm_q != IDLE);

endmodule
